// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the 128-bit line memory port between icache and dcache
// One transaction in flight; a WAIT that runs TIMEOUT cycles without mem_ready_i re-issues the request.
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk_i,
   input  logic         rsn_i,
   input  logic         ic_rqst_i,
   input  logic [19:0]  ic_addr_i,
   output logic         ic_ready_o,
   output logic [127:0] ic_data_o,
   output logic [19:0]  ic_addr_o,
   input  logic         dc_rqst_i,
   input  logic         dc_we_i,
   input  logic [19:0]  dc_addr_i,
   input  logic [31:0]  dc_wdata_i,
   output logic         dc_ready_o,
   output logic [127:0] dc_data_o,
   output logic [19:0]  dc_addr_o,
   output logic         mem_rqst_o,
   output logic         mem_we_o,
   output logic [19:0]  mem_addr_o,
   output logic [31:0]  mem_wdata_o,
   input  logic         mem_ready_i,
   input  logic [127:0] mem_data_i,
   output logic [1:0]   grant_o,
   output logic [7:0]   retry_cnt_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] to_cnt;
   logic       last_dc;
   logic       ic_win, dc_win, timeout_hit;

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // On contention the requester that did not win last time goes first.
   always_comb begin
      state_nxt   = state;
      ic_win      = 1'b0;
      dc_win      = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            ic_win = ic_rqst_i & (~dc_rqst_i | last_dc);
            dc_win = dc_rqst_i & ~ic_win;
            if (ic_win | dc_win) state_nxt = ISSUE;
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (mem_ready_i) begin
               state_nxt = RESP;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ISSUE;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         ic_ready_o  <= 1'b0;
         ic_data_o   <= '0;
         ic_addr_o   <= '0;
         dc_ready_o  <= 1'b0;
         dc_data_o   <= '0;
         dc_addr_o   <= '0;
         mem_rqst_o  <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         grant_o     <= '0;
         retry_cnt_o <= '0;
         to_cnt      <= '0;
         last_dc     <= 1'b1;
      end else begin
         mem_rqst_o <= (state_nxt == ISSUE);
         ic_ready_o <= 1'b0;
         dc_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ic_win) begin
                  grant_o    <= 2'b01;
                  mem_addr_o <= ic_addr_i;
                  mem_we_o   <= 1'b0;
               end else if (dc_win) begin
                  grant_o     <= 2'b10;
                  mem_addr_o  <= dc_addr_i;
                  mem_we_o    <= dc_we_i;
                  mem_wdata_o <= dc_wdata_i;
               end else begin
                  grant_o <= '0;
               end
            end
            ISSUE: to_cnt <= '0;
            WAIT: begin
               to_cnt <= to_cnt + 8'd1;
               if (mem_ready_i) begin
                  if (grant_o[0]) begin
                     ic_data_o  <= mem_data_i;
                     ic_addr_o  <= mem_addr_o;
                     ic_ready_o <= 1'b1;
                  end else begin
                     // A write completion returns no line; keep the last one.
                     if (!mem_we_o) dc_data_o <= mem_data_i;
                     dc_addr_o  <= mem_addr_o;
                     dc_ready_o <= 1'b1;
                  end
               end else if (timeout_hit && retry_cnt_o != 8'hFF) begin
                  retry_cnt_o <= retry_cnt_o + 8'd1;
               end
            end
            RESP: begin
               last_dc <= grant_o[1];
               grant_o <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit line memory port between the instruction cache refill path and the data cache refill/write-through path.
- Accepts level-held requests from both caches and grants them round-robin. Only one memory transaction is in flight at a time.
- Issues each transaction to memory and returns the line, tagged with its address, to the winning requester.
- Re-issues a transaction when memory does not respond within a timeout.

Parameters:
TIMEOUT, 255, number of WAIT cycles without mem_ready_i before the transaction is re-issued (legal range 1..255).

Ports:
clk_i  input  1  clock; all state changes on rising edge.
rsn_i  input  1  reset; asynchronous, active-high (1 = reset).
ic_rqst_i  input  1  icache line-read request, held until ic_ready_o.
ic_addr_i  input  20  icache request byte address; stable while ic_rqst_i is high.
ic_ready_o  output  1  one-cycle pulse: line for icache valid.
ic_data_o  output  128  returned line for icache.
ic_addr_o  output  20  address of the returned icache line.
dc_rqst_i  input  1  dcache request, held until dc_ready_o.
dc_we_i  input  1  1 = word write, 0 = line read.
dc_addr_i  input  20  dcache request byte address.
dc_wdata_i  input  32  write data.
dc_ready_o  output  1  one-cycle pulse: dcache transaction complete.
dc_data_o  output  128  returned line for dcache.
dc_addr_o  output  20  address of the completed dcache transaction.
mem_rqst_o  output  1  one-cycle request pulse to memory.
mem_we_o  output  1  write enable of the current transaction.
mem_addr_o  output  20  address of the current transaction.
mem_wdata_o  output  32  write data of the current transaction.
mem_ready_i  input  1  memory completion; mem_data_i is valid in the same cycle.
mem_data_i  input  128  line from memory.
grant_o  output  2  one-hot owner: bit0 = icache, bit1 = dcache; 00 when idle.
retry_cnt_o  output  8  saturating count of timeout re-issues since reset.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; timeout counter 0.
  - last_grant = dcache, so icache wins the first contention after reset.
- All outputs are registered.
- Reset asserted mid-transaction abandons the transaction. No ready_o pulse is produced. A late mem_ready_i arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sampled at each edge. Only one rqst high: that requester wins. Both high: the requester that is not last_grant wins.
  - On a win: latch the winner's addr into mem_addr_o.
    - dcache winner: latch we/wdata into mem_we_o/mem_wdata_o.
    - icache winner: mem_we_o = 0, mem_wdata_o unchanged.
  - Set grant_o and go to ISSUE.
  - No request: stay in IDLE, grant_o = 00.
- ISSUE:
  - mem_rqst_o = 1 for exactly this cycle.
  - Timeout counter cleared.
  - mem_ready_i is ignored in this cycle.
  - Next state: WAIT.
- WAIT:
  - mem_rqst_o = 0. mem_addr_o, mem_we_o and mem_wdata_o hold their values.
  - Counter increments each cycle.
  - mem_ready_i = 1: capture mem_data_i into the winner's data_o, then go to RESP. On writes, dc_data_o is not updated.
  - Otherwise, counter == TIMEOUT-1: go to ISSUE (WAIT lasts exactly TIMEOUT cycles) and increment retry_cnt_o, saturating at 255.
  - mem_ready_i in the timeout cycle: the response wins and no retry occurs.
- RESP:
  - Winner's ready_o = 1 for this cycle only.
  - Winner's addr_o = latched address.
  - last_grant = winner; grant_o cleared on exit.
  - Next state: IDLE.
- Requester obligation: deassert rqst_i in the cycle following its ready_o. The IDLE cycle after RESP therefore does not re-grant the same request.
- Latency: rqst_i sampled at edge 0 → ISSUE in cycle 1 → first WAIT cycle 2. mem_ready_i in that first WAIT cycle gives ready_o in cycle 3 (minimum latency 3).
- Starvation bound: under continuous contention grants alternate icache, dcache, icache, and so on.
- The losing requester's rqst_i remains pending and is not dropped.
- data_o/addr_o of each requester hold their value until that requester's next completion.

Test Plan:
1. Single icache read: ic_addr_i = 0x12340, memory answers 2 cycles after mem_rqst_o with 0xAAAA…AAAA (128 bits).
   - mem_rqst_o is a single-cycle pulse with mem_addr_o = 0x12340 and mem_we_o = 0.
   - ic_ready_o pulses once; ic_data_o = 0xAAAA…AAAA; ic_addr_o = 0x12340.
   - dc_ready_o stays 0.
2. Contention: both rqst high from the first cycle after reset, held and re-raised after each ready, memory latency 1.
   - Grant order is icache, dcache, icache, dcache.
   - grant_o = 01, 10, 01, 10.
3. dcache write: dc_we_i = 1, dc_addr_i = 0x00F04, dc_wdata_i = 0xDEADBEEF.
   - mem_we_o = 1 and mem_wdata_o = 0xDEADBEEF throughout ISSUE/WAIT.
   - dc_ready_o pulses; dc_addr_o = 0x00F04; dc_data_o unchanged from its prior value.
4. Timeout with TIMEOUT = 4, no mem_ready_i.
   - mem_rqst_o re-pulses exactly 5 cycles after the first pulse (4 WAIT cycles plus ISSUE), repeating.
   - retry_cnt_o = 1, 2, …
   - Raising mem_ready_i afterwards completes the transaction normally.
5. Timeout with TIMEOUT = 4 and mem_ready_i exactly in the 4th WAIT cycle.
   - Transaction completes; no re-issue; retry_cnt_o stays 0.
6. Reset mid-transaction: assert rsn_i during WAIT of an icache read, release, then drive mem_ready_i = 1 for one cycle.
   - All outputs are 0 immediately on assertion.
   - No ic_ready_o/dc_ready_o pulse; grant_o = 00.
   - The next request is served normally.
